// File: rtl/mult_div_ctrl.sv
// Sequencer for the shared iterative multiply/divide unit: load, step CYCLES times,
// commit to HI/LO and signal completion; a zero divisor raises a one-cycle exception instead.
module mult_div_ctrl #(
   parameter int CYCLES = 32,
   parameter int CNT_W  = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op_div,
   input  logic             divisor_zero,
   output logic             md_busy,
   output logic             md_load,
   output logic             md_step,
   output logic             md_div,
   output logic [CNT_W-1:0] md_count,
   output logic             hilo_write,
   output logic             md_done,
   output logic             div0_exc
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_EXC   = 3'd5;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

   logic [2:0]       state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             div_reg, div_next;

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      div_next   = div_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               div_next   = op_div;
               state_next = (op_div && divisor_zero) ? S_EXC : S_LOAD;
            end
         end
         S_LOAD: begin
            count_next = '0;
            state_next = S_RUN;
         end
         S_RUN: begin
            // The counter stops on the last index so it never wraps.
            if (count_reg == LAST) begin
               state_next = S_WRITE;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
         S_WRITE: state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         S_EXC:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= S_IDLE;
         count_reg <= '0;
         div_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         div_reg   <= div_next;
      end
   end

   // All outputs decode registered state only.
   assign md_busy    = (state_reg != S_IDLE);
   assign md_load    = (state_reg == S_LOAD);
   assign md_step    = (state_reg == S_RUN);
   assign hilo_write = (state_reg == S_WRITE);
   assign md_done    = (state_reg == S_DONE);
   assign div0_exc   = (state_reg == S_EXC);
   assign md_div     = div_reg;
   assign md_count   = count_reg;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench: two sequencers (CYCLES=32 and CYCLES=1) share stimulus; a per-cycle
// reference model pushes expected outputs, a negedge monitor pops and compares them.
module tb_mult_div_ctrl;

   typedef struct packed {
      logic       busy;
      logic       load;
      logic       step;
      logic       div;
      logic       hw;
      logic       done;
      logic       exc;
      logic       cnt_chk;
      logic [5:0] cnt;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic op_div = 1'b0;
   logic divisor_zero = 1'b0;

   logic       busy0, load0, step0, div0, hw0, done0, exc0;
   logic [5:0] cnt0;
   logic       busy1, load1, step1, div1, hw1, done1, exc1;
   logic [1:0] cnt1;

   exp_t obs0, obs1;
   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   int cur[2];
   bit exc_op[2];
   bit mdiv[2];
   int cyc_p[2];

   always #5 clock = ~clock;

   mult_div_ctrl #(.CYCLES(32), .CNT_W(6)) dut0 (
      .clock(clock), .reset(reset), .start(start), .op_div(op_div),
      .divisor_zero(divisor_zero), .md_busy(busy0), .md_load(load0),
      .md_step(step0), .md_div(div0), .md_count(cnt0), .hilo_write(hw0),
      .md_done(done0), .div0_exc(exc0)
   );

   mult_div_ctrl #(.CYCLES(1), .CNT_W(2)) dut1 (
      .clock(clock), .reset(reset), .start(start), .op_div(op_div),
      .divisor_zero(divisor_zero), .md_busy(busy1), .md_load(load1),
      .md_step(step1), .md_div(div1), .md_count(cnt1), .hilo_write(hw1),
      .md_done(done1), .div0_exc(exc1)
   );

   assign obs0 = {busy0, load0, step0, div0, hw0, done0, exc0, 1'b0, cnt0};
   assign obs1 = {busy1, load1, step1, div1, hw1, done1, exc1, 1'b0, 4'b0000, cnt1};

   // Reference: an operation is tracked as its offset k from the accepted start edge.
   task automatic model(input int d, input logic r, input logic s, input logic od,
                        input logic dz, output exp_t e);
      int c;
      int k;
      int endk;
      c = cyc_p[d];
      e = '0;
      if (r) begin
         cur[d]    = 0;
         mdiv[d]   = 1'b0;
         exc_op[d] = 1'b0;
         e.cnt_chk = 1'b1;
      end else begin
         if (cur[d] == 0) begin
            if (s) begin
               cur[d]    = 1;
               mdiv[d]   = od;
               exc_op[d] = od && dz;
            end
         end else begin
            endk   = exc_op[d] ? 1 : c + 3;
            cur[d] = cur[d] + 1;
            if (cur[d] > endk) cur[d] = 0;
         end
         k      = cur[d];
         e.div  = mdiv[d];
         e.busy = (k != 0);
         if (k != 0) begin
            if (exc_op[d]) begin
               e.exc = 1'b1;
            end else if (k == 1) begin
               e.load = 1'b1;
            end else if (k <= c + 1) begin
               e.step    = 1'b1;
               e.cnt_chk = 1'b1;
               e.cnt     = 6'(k - 2);
            end else if (k == c + 2) begin
               e.hw      = 1'b1;
               e.cnt_chk = 1'b1;
               e.cnt     = 6'(c - 1);
            end else begin
               e.done    = 1'b1;
               e.cnt_chk = 1'b1;
               e.cnt     = 6'(c - 1);
            end
         end
      end
   endtask

   task automatic chk(input int d, input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL dut%0d %s at cycle %0d: got %0d, expected %0d", d, name, cyc_n, act, exp);
      end
   endtask

   task automatic compare(input int d, input exp_t e, input exp_t o);
      chk(d, "md_busy", int'(o.busy), int'(e.busy));
      chk(d, "md_load", int'(o.load), int'(e.load));
      chk(d, "md_step", int'(o.step), int'(e.step));
      chk(d, "md_div", int'(o.div), int'(e.div));
      chk(d, "hilo_write", int'(o.hw), int'(e.hw));
      chk(d, "md_done", int'(o.done), int'(e.done));
      chk(d, "div0_exc", int'(o.exc), int'(e.exc));
      if (e.cnt_chk) chk(d, "md_count", int'(o.cnt), int'(e.cnt));
      chk(d, "strobe_onehot",
          int'($countones({o.load, o.step, o.hw, o.done, o.exc}) <= 1), 1);
      if (o.done || o.exc)
         $display("dut%0d cycle %0d: %s complete, md_div=%0d", d, cyc_n,
                  o.exc ? "div0 exception" : "operation", o.div);
   endtask

   always @(negedge clock) begin
      if (q0.size() > 0) compare(0, q0.pop_front(), obs0);
      if (q1.size() > 0) compare(1, q1.pop_front(), obs1);
   end

   // One cycle of stimulus: drive inputs, predict the next cycle, wait for the edge.
   task automatic cyc(input logic r, input logic s, input logic od, input logic dz);
      exp_t e;
      reset        = r;
      start        = s;
      op_div       = od;
      divisor_zero = dz;
      model(0, r, s, od, dz, e);
      q0.push_back(e);
      model(1, r, s, od, dz, e);
      q1.push_back(e);
      @(posedge clock);
      #1;
      cyc_n++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      cyc_p[0] = 32;
      cyc_p[1] = 1;
      for (int i = 0; i < 2; i++) begin
         cur[i]    = 0;
         exc_op[i] = 1'b0;
         mdiv[i]   = 1'b0;
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

      // MULT with ignored starts at 5, 20, 35 and an accepted one at 36
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 75; c++)
         cyc(1'b0, (c == 5 || c == 20 || c == 35 || c == 36), 1'b0, 1'b0);

      // divide by zero, with a start in the EXC cycle and the following idle cycle
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      idle(40);

      // normal DIV
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      idle(40);

      // reset in the middle of RUN, then a fresh start
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      for (int c = 1; c <= 9; c++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(40);

      // random traffic
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(299) == 0), ($urandom_range(7) == 0),
             1'($urandom_range(1)), 1'($urandom_range(1)));
      idle(40);

      @(negedge clock);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Sequencer for the shared multiply/divide unit of the multicycle datapath. It accepts a one-cycle start from the main control FSM and loads the MD operand registers. It then steps the iterative mult/div datapath for a fixed number of cycles, commits the result to HI/LO, and reports completion. A divide by zero is detected at start and raised as a one-cycle exception; in that case HI/LO are never touched.

Parameters:
CYCLES, 32, number of iteration cycles; legal range 1 to 2^CNT_W-1.
CNT_W, 6, width of the iteration counter.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request from main control; sampled only in IDLE.
op_div  input  1  operation select at start: 1 = DIV, 0 = MULT.
divisor_zero  input  1  divisor operand equals zero; sampled with start.
md_busy  output  1  unit occupied; main control stalls while high.
md_load  output  1  load operand/working registers of the MD datapath.
md_step  output  1  advance MD datapath by one iteration.
md_div  output  1  latched op_div for the running operation.
md_count  output  CNT_W  current iteration index.
hilo_write  output  1  write enable for HI and LO.
md_done  output  1  one-cycle completion pulse.
div0_exc  output  1  one-cycle divide-by-zero exception pulse.

Behaviour:
- Moore FSM with states IDLE, LOAD, RUN, WRITE, DONE, EXC. All outputs are decoded from registered state/counter; no combinational path exists from any input to any output.
- Reset (synchronous, active-high) sets state to IDLE. All outputs read 0 after the reset edge, including md_count = 0 and md_div = 0. Reset overrides everything, including mid-RUN.
- IDLE:
  - md_busy = 0.
  - start = 1 with op_div = 1 and divisor_zero = 1 goes to EXC.
  - start = 1 otherwise goes to LOAD.
  - md_div captures op_div on the start edge in both cases.
- LOAD: md_load = 1 for exactly one cycle; md_count is cleared to 0; next state is RUN.
- RUN:
  - md_step = 1 every cycle.
  - md_count shows the iteration index (0 to CYCLES-1) and increments by 1 each cycle.
  - When md_count == CYCLES-1, the next state is WRITE and md_count holds.
  - RUN lasts exactly CYCLES cycles.
- WRITE: hilo_write = 1 for exactly one cycle; next state is DONE.
- DONE: md_done = 1 for exactly one cycle; next state is IDLE.
- EXC:
  - div0_exc = 1 for exactly one cycle; next state is IDLE.
  - md_load, md_step, hilo_write and md_done all stay 0.
- md_busy = 1 in every state except IDLE.
- md_div holds its value from the start edge until the next accepted start.
- start is ignored while md_busy = 1; it is neither queued nor counted.
- A start in the DONE/EXC cycle is dropped. start in the first IDLE cycle afterwards is accepted, so back-to-back operations are separated by one idle cycle.
- divisor_zero is ignored when op_div = 0, and is ignored outside the start edge.
- Latency: start high in cycle 0 gives LOAD in cycle 1, RUN in cycles 2 to CYCLES+1, WRITE in cycle CYCLES+2, DONE in cycle CYCLES+3, and IDLE in cycle CYCLES+4.
- At most one of md_load, md_step, hilo_write, md_done, div0_exc is high in any cycle.
- With CYCLES = 1, RUN occupies a single cycle with md_count = 0.
- The counter never wraps; CYCLES >= 2^CNT_W is illegal configuration.

Test Plan:
- MULT: start = 1, op_div = 0 in cycle 0 -> md_load in cycle 1; md_step in cycles 2 to 33 with md_count 0 to 31; hilo_write in cycle 34; md_done in cycle 35; md_busy high in cycles 1 to 35; md_div = 0.
- DIV by zero: start = 1, op_div = 1, divisor_zero = 1 -> div0_exc = 1 in cycle 1 only; md_busy high in cycle 1 only; no md_load, md_step or hilo_write; IDLE in cycle 2.
- Ignored requests:
  - DIV with divisor_zero = 0 proceeds normally with md_div = 1.
  - start pulses in cycles 5, 20 and 35 (DONE) are ignored; timing matches the MULT case.
  - start in cycle 36 is accepted with md_load in cycle 37.
- Reset mid-operation: assert reset in cycle 10 (RUN, md_count = 8) -> at cycle 11 all outputs are 0 and state is IDLE; no hilo_write ever occurs; a new start in cycle 12 gives a full sequence.
- divisor_zero = 1 with op_div = 0 -> normal MULT sequence, div0_exc stays 0.
- CYCLES = 1, CNT_W = 2 -> LOAD in cycle 1, a single md_step in cycle 2, hilo_write in cycle 3, md_done in cycle 4; one-hot check of the strobes holds in every cycle.
